// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch controller with a small prefetch queue. A PC register
// addresses a combinational instruction ROM; each fetched word is pushed
// together with its byte address into a DEPTH-entry circular queue whose head
// is presented to the consumer with a valid/ready handshake.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   imem_address     byte address to the ROM (the PC register)
//   imem_instruction ROM read data for imem_address, same cycle
//   redirect         flush the queue and restart fetch at redirect_pc
//   redirect_pc      new fetch byte address
//   out_valid        queue head holds an instruction
//   out_ready        consumer accepts the head this cycle
//   out_instr        head instruction
//   out_pc           head instruction byte address
//   fetch_fault      sticky misaligned-redirect indication
//
// Modes: FETCH pushes one word per cycle while there is room, DRAIN stops
// fetching once the PC runs off the end of the ROM, FAULT parks after a
// misaligned redirect until an aligned redirect arrives.
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_fault
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // 65 bits so pc+3 near the top of the address space cannot wrap.
    localparam logic [64:0]   MEM_LIM = 65'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic            fault_q, fault_d;

    // Queue storage needs no reset: count gates every read of it.
    logic [31:0]     instr_q [DEPTH];
    logic [63:0]     epc_q   [DEPTH];

    logic            pop;
    logic            push;
    logic            at_end;
    logic            redir_misal;

    assign out_valid    = (count_q != '0);
    assign pop          = out_valid && out_ready;
    assign at_end       = ({1'b0, pc_q} + 65'd3) >= MEM_LIM;
    assign redir_misal  = (redirect_pc[1:0] != 2'b00);

    assign imem_address = pc_q;
    assign out_instr    = instr_q[head_q];
    assign out_pc       = epc_q[head_q];
    assign fetch_fault  = fault_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Redirect overrides everything, from any state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = redir_misal ? S_FAULT : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: if (at_end) state_d = S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. A push needs room, or a simultaneous pop freeing a slot,
    // and never happens on the cycle the PC has run past the ROM.
    // ------------------------------------------------------------------
    always_comb begin
        push = 1'b0;
        if ((state_q == S_FETCH) && !redirect && !at_end) begin
            push = (count_q < DEPTH_C) || pop;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fault_d = fault_q;
        if (redirect) begin
            // Any pop this cycle is simply absorbed by the flush.
            pc_d    = redirect_pc;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            fault_d = redir_misal;
        end else begin
            if (push) begin
                pc_d   = pc_q + 64'd4;
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[tail_q] <= imem_instruction;
            epc_q[tail_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    localparam int          DEPTH    = 4;
    localparam int          MEM_SIZE = 1024;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch_ctrl #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC),
        .MEM_SIZE(MEM_SIZE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // ROM: word i holds i; outside the ROM a marker value.
    function automatic logic [31:0] romw(input logic [63:0] a);
        if (a < 64'(MEM_SIZE)) return a[33:2];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instruction = romw(imem_address);

    // Reference model: a queue of fetched (pc, word) pairs plus a fetch mode.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] mpc;
    int          mmode;   // 0 fetching, 1 ran off ROM end, 2 faulted
    logic        mfault;

    task automatic model_reset();
        mq.delete();
        mpc    = RESET_PC;
        mmode  = 0;
        mfault = 1'b0;
    endtask

    task automatic model_edge(input logic rd, input logic [63:0] rpc, input logic rdy);
        bit popped;
        ent_t e;
        popped = (mq.size() != 0) && rdy;
        if (rd) begin
            mq.delete();
            mpc = rpc;
            if (rpc[1:0] != 2'b00) begin
                mmode  = 2;
                mfault = 1'b1;
            end else begin
                mmode  = 0;
                mfault = 1'b0;
            end
        end else begin
            if (popped) void'(mq.pop_front());
            if (mmode == 0) begin
                if (mpc + 3 >= 64'(MEM_SIZE)) begin
                    mmode = 1;
                end else if (mq.size() < DEPTH) begin
                    e.pc  = mpc;
                    e.ins = romw(mpc);
                    mq.push_back(e);
                    mpc = mpc + 4;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
        chk("imem_address", imem_address, mpc);
        chk("fetch_fault", {63'd0, fetch_fault}, {63'd0, mfault});
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", {32'd0, out_instr}, {32'd0, mq[0].ins});
        end
    endtask

    // Drive inputs after a falling edge, advance the model, clock, check.
    task automatic step(input logic rd, input logic [63:0] rpc, input logic rdy);
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        model_edge(rd, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Reset pulse fully between two rising edges.
    task automatic rst_pulse();
        #1 reset_n = 1'b0;
        #1 model_reset();
        chk("async_valid", {63'd0, out_valid}, 64'd0);
        chk("async_pc", imem_address, RESET_PC);
        chk("async_fault", {63'd0, fetch_fault}, 64'd0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic        rd;
        logic        rdy;
        logic [63:0] rpc;
        int          sel;

        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        out_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        reset_n = 1'b1;

        // Streaming from reset, consumer always ready.
        step(1'b0, 64'h0, 1'b1);
        chk("first_pc", out_pc, 64'h0);
        chk("first_instr", {32'd0, out_instr}, 64'h0);
        repeat (8) step(1'b0, 64'h0, 1'b1);

        // Back-pressure: queue fills and fetch stalls.
        step(1'b1, 64'h0, 1'b0);
        repeat (10) step(1'b0, 64'h0, 1'b0);
        chk("sat_imem", imem_address, 64'h10);
        chk("sat_head", out_pc, 64'h0);
        repeat (5) step(1'b0, 64'h0, 1'b1);

        // Redirect with three entries queued and a pop in flight.
        step(1'b1, 64'h0, 1'b0);
        repeat (3) step(1'b0, 64'h0, 1'b0);
        step(1'b1, 64'h40, 1'b1);
        chk("redir_empty", {63'd0, out_valid}, 64'd0);
        step(1'b0, 64'h0, 1'b1);
        chk("redir_pc", out_pc, 64'h40);
        repeat (2) step(1'b0, 64'h0, 1'b1);

        // Misaligned redirect faults; aligned redirect recovers.
        step(1'b1, 64'h42, 1'b1);
        chk("fault_set", {63'd0, fetch_fault}, 64'd1);
        repeat (4) step(1'b0, 64'h0, 1'b1);
        chk("fault_idle", {63'd0, out_valid}, 64'd0);
        step(1'b1, 64'h80, 1'b1);
        chk("fault_clr", {63'd0, fetch_fault}, 64'd0);
        step(1'b0, 64'h0, 1'b1);
        chk("fault_exit_pc", out_pc, 64'h80);

        // Fetch to the end of the ROM, then drain.
        step(1'b1, 64'h3F8, 1'b1);
        repeat (6) step(1'b0, 64'h0, 1'b1);
        chk("drain_imem", imem_address, 64'h400);
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with a full queue.
        step(1'b1, 64'h100, 1'b0);
        repeat (6) step(1'b0, 64'h0, 1'b0);
        rst_pulse();
        repeat (4) step(1'b0, 64'h0, 1'b1);

        // Randomised traffic against the model.
        repeat (800) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 7);
            if (sel == 0)
                rpc = (64'($urandom_range(0, 255)) << 2) | 64'($urandom_range(1, 3));
            else if (sel == 1)
                rpc = 64'h3E0 + (64'($urandom_range(0, 7)) << 2);
            else
                rpc = 64'($urandom_range(0, 255)) << 2;
            step(rd, rpc, rdy);
            if ($urandom_range(0, 99) == 0) rst_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
